// File: rtl/bound_flasher_monitor_if.sv
// Bound-flasher LED bus: the flick request plus the 16-bit thermometer LED bus.
// Latency: none, wires only.
// Backpressure: none; the bus is free-running and sampled every clock.
interface bound_flasher_monitor_if;
  logic        flick;
  logic [15:0] led;

  // Driver side (the flasher, or a bench standing in for it)
  modport master (output flick, led);
  // Observer side (the monitor)
  modport slave  (input flick, led);
endinterface

// File: rtl/bound_flasher_monitor.sv
// Passive checker for the bound-flasher LED bus: predicts each LED value, flags deviations, counts sequences.
// Latency: every output is registered and reflects the values sampled at the most recent clock edge.
// Backpressure: none; the monitor only observes the bus and never stalls the flasher.
module bound_flasher_monitor #(
  parameter int SEQ_CNT_W = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bound_flasher_monitor_if.slave   bus,
  input  logic                     err_clr,
  output logic [3:0]               phase,
  output logic [4:0]               lit_cnt,
  output logic                     err,
  output logic [1:0]               err_code,
  output logic [ERR_CNT_W-1:0]     err_cnt,
  output logic                     seq_done,
  output logic [SEQ_CNT_W-1:0]     seq_count
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    FILL6   = 4'd1,
    DRAIN6  = 4'd2,
    FILL11  = 4'd3,
    DRAIN11 = 4'd4,
    FILL16  = 4'd5,
    DRAIN16 = 4'd6,
    DRAIN5  = 4'd7,
    RESYNC  = 4'd8
  } state_t;

  localparam logic [1:0] CODE_NONE  = 2'd0;
  localparam logic [1:0] CODE_THERM = 2'd1;
  localparam logic [1:0] CODE_VALUE = 2'd2;
  localparam logic [1:0] CODE_START = 2'd3;

  state_t      state, state_nxt;
  logic [15:0] exp_led, exp_nxt;
  // Set when the model has just left DRAIN16 for IDLE; the following edge confirms the final 0.
  logic        done_pend, done_pend_nxt;

  logic        flick;
  logic [15:0] led;
  assign flick = bus.flick;
  assign led   = bus.led;

  logic        chk_err;
  logic [1:0]  chk_code;
  logic [15:0] fill_v, drain_v;
  logic        thermo;

  logic                 err_nxt;
  logic [1:0]           code_nxt;
  logic [ERR_CNT_W-1:0] cnt_nxt;
  logic                 done_nxt;
  logic [SEQ_CNT_W-1:0] seqc_nxt;
  logic [4:0]           lit_nxt;

  // A value of the form 2^n-1 has no bit in common with its successor (0xFFFF wraps to 0).
  assign thermo  = ((led & (led + 16'd1)) == 16'd0);
  assign fill_v  = {exp_led[14:0], 1'b1};
  assign drain_v = {1'b0, exp_led[15:1]};

  assign phase = state;

  // State register: model state, prediction and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      exp_led   <= '0;
      done_pend <= 1'b0;
      lit_cnt   <= '0;
      err       <= 1'b0;
      err_code  <= CODE_NONE;
      err_cnt   <= '0;
      seq_done  <= 1'b0;
      seq_count <= '0;
    end else begin
      state     <= state_nxt;
      exp_led   <= exp_nxt;
      done_pend <= done_pend_nxt;
      lit_cnt   <= lit_nxt;
      err       <= err_nxt;
      err_code  <= code_nxt;
      err_cnt   <= cnt_nxt;
      seq_done  <= done_nxt;
      seq_count <= seqc_nxt;
    end
  end

  // Next-state logic: check the sampled bus against the prediction, then advance the model.
  always_comb begin
    state_nxt     = state;
    exp_nxt       = exp_led;
    done_pend_nxt = 1'b0;
    chk_err       = 1'b0;
    chk_code      = CODE_NONE;

    if (state != RESYNC) begin
      if (!thermo) begin
        chk_err  = 1'b1;
        chk_code = CODE_THERM;
      end else if (state == IDLE && exp_led == 16'd0 && led != 16'd0) begin
        chk_err  = 1'b1;
        chk_code = CODE_START;
      end else if (led != exp_led) begin
        chk_err  = 1'b1;
        chk_code = CODE_VALUE;
      end
    end

    if (chk_err) begin
      state_nxt = RESYNC;
      exp_nxt   = '0;
    end else begin
      unique case (state)
        IDLE, RESYNC: begin
          // RESYNC waits for a dark bus, then behaves exactly like IDLE on that edge.
          if (state == IDLE || led == 16'd0) begin
            if (flick) begin
              state_nxt = FILL6;
              exp_nxt   = 16'h0001;
            end else begin
              state_nxt = IDLE;
              exp_nxt   = '0;
            end
          end
        end
        FILL6: begin
          exp_nxt = fill_v;
          if (fill_v == 16'h003F) state_nxt = DRAIN6;
        end
        DRAIN6: begin
          exp_nxt = drain_v;
          if (drain_v == 16'h0000) state_nxt = FILL11;
        end
        FILL11: begin
          exp_nxt = fill_v;
          if (flick && fill_v == 16'h003F) state_nxt = DRAIN6;
          else if (fill_v == 16'h07FF)     state_nxt = flick ? DRAIN11 : DRAIN5;
        end
        DRAIN11: begin
          exp_nxt = drain_v;
          if (drain_v == 16'h0000) state_nxt = FILL11;
        end
        DRAIN5: begin
          exp_nxt = drain_v;
          if (drain_v == 16'h001F) state_nxt = FILL16;
        end
        FILL16: begin
          exp_nxt = fill_v;
          if (flick && (fill_v == 16'h003F || fill_v == 16'h07FF)) state_nxt = DRAIN5;
          else if (fill_v == 16'hFFFF)                              state_nxt = DRAIN16;
        end
        DRAIN16: begin
          exp_nxt = drain_v;
          if (drain_v == 16'h0000) begin
            state_nxt     = IDLE;
            done_pend_nxt = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
          exp_nxt   = '0;
        end
      endcase
    end
  end

  // Output logic: error bookkeeping, sequence counting and LED popcount.
  always_comb begin
    err_nxt  = err;
    code_nxt = err_code;
    cnt_nxt  = err_cnt;
    if (err_clr) begin
      err_nxt  = 1'b0;
      code_nxt = CODE_NONE;
      cnt_nxt  = '0;
    end
    // A detection on the same edge as a clear still lands, so it is never lost.
    if (chk_err) begin
      err_nxt = 1'b1;
      if (code_nxt == CODE_NONE) code_nxt = chk_code;
      if (cnt_nxt != {ERR_CNT_W{1'b1}}) cnt_nxt = cnt_nxt + ERR_CNT_W'(1);
    end

    done_nxt = done_pend && !chk_err;
    seqc_nxt = seq_count + SEQ_CNT_W'(done_nxt);

    lit_nxt = '0;
    for (int i = 0; i < 16; i++) begin
      lit_nxt = lit_nxt + {4'd0, led[i]};
    end
  end

endmodule
